// File: rtl/lcd_msg_scheduler_pkg.sv
// Shared definitions for the LCD message scheduler: FSM states, frame geometry
// and the round-robin pointer helper.
package lcd_msg_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DWELL = 2'd2
  } lcd_state_e;

  localparam logic [7:0]  LCD_BLANK_CHAR = 8'h20;
  localparam int unsigned LCD_MSG_W      = 256;
  localparam int unsigned LCD_LINE_CHARS = 16;

  // Pointer moves to the slot just after the winner, wrapping at nreq.
  function automatic logic [2:0] rr_next(input logic [2:0] id, input int unsigned nreq);
    return ((32'(id) + 32'd1) >= nreq) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/lcd_msg_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: lowest pending index at or above ptr wins,
// otherwise the search wraps to the lowest pending index overall.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_id,
  output logic            any
);

  logic [NREQ-1:0]   mask;
  logic [2*NREQ-1:0] search;
  logic              found;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      mask[i] = (i >= {29'd0, ptr});
    end
    // Lower half holds requests at/above ptr, upper half the full set for wrap.
    search   = {req, req & mask};
    found    = 1'b0;
    grant    = '0;
    grant_id = '0;
    for (int unsigned i = 0; i < 2*NREQ; i++) begin
      if (!found && search[i]) begin
        found              = 1'b1;
        grant[i % NREQ]    = 1'b1;
        grant_id           = 3'(i % NREQ);
      end
    end
    any = found;
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Shares one 16x2 LCD among several producers: round-robin grant, atomic frame
// latch, and a minimum dwell time per granted frame.
module lcd_msg_scheduler
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned MSG_W       = LCD_MSG_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*MSG_W-1:0] msg_in,
  output logic [NREQ-1:0]       ack,
  output logic [MSG_W-1:0]      message_out,
  output logic [2:0]            active_id,
  output logic                  valid,
  output logic                  busy
);

  localparam logic [MSG_W-1:0] BLANK_FRAME = {(MSG_W/8){LCD_BLANK_CHAR}};
  localparam logic [15:0]      HOLD_LOAD   = 16'(HOLD_CYCLES - 1);

  lcd_state_e        state_q, state_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [2:0]        active_id_q, active_id_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   arb_grant;
  logic [2:0]        arb_id;
  logic              arb_any;
  logic [MSG_W-1:0]  win_msg;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req      (req),
    .ptr      (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  always_comb begin
    win_msg = msg_in[MSG_W-1:0];
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_id == 3'(i)) begin
        win_msg = msg_in[i*MSG_W +: MSG_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    msg_d       = msg_q;
    ack_d       = '0;
    active_id_d = active_id_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE, S_DWELL: begin
        if (arb_any) begin
          msg_d       = win_msg;
          ack_d       = arb_grant;
          active_id_d = arb_id;
          valid_d     = 1'b1;
          rr_ptr_d    = rr_next(arb_id, NREQ);
          hold_cnt_d  = HOLD_LOAD;
          busy_d      = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_DWELL;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      msg_q       <= BLANK_FRAME;
      ack_q       <= '0;
      active_id_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      msg_q       <= msg_d;
      ack_q       <= ack_d;
      active_id_q <= active_id_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign ack         = ack_q;
  assign message_out = msg_q;
  assign active_id   = active_id_q;
  assign valid       = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Scoreboard bench for lcd_msg_scheduler: stimulus queues expected grants,
// a negedge monitor pops and compares whenever ack is seen.
module tb_lcd_msg_scheduler;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned MSG_W = 256;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*MSG_W-1:0] msg_in = '0;
  logic [NREQ-1:0]       ack;
  logic [MSG_W-1:0]      message_out;
  logic [2:0]            active_id;
  logic                  valid;
  logic                  busy;

  lcd_msg_scheduler #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .MSG_W       (MSG_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .msg_in      (msg_in),
    .ack         (ack),
    .message_out (message_out),
    .active_id   (active_id),
    .valid       (valid),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   ack;
    logic [2:0]   id;
    logic [255:0] msg;
    int unsigned  cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic [255:0] blank, f_a, f_b, f_c, f_d;

  function automatic logic [255:0] mkframe(input string s);
    logic [255:0] f;
    f = {32{8'h20}};
    for (int k = 0; k < 32 && k < s.len(); k++) f[8*k +: 8] = s[k];
    return f;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [2:0] id, input logic [255:0] m,
                      input int unsigned c);
    exp_t e;
    e.ack = a; e.id = id; e.msg = m; e.cyc = c;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (ack !== 3'b000) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=%b id=%0d expected no ack (cycle %0d)", ack, active_id, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_vec",   256'(ack),       256'(e.ack));
        chk("active_id", 256'(active_id), 256'(e.id));
        chk("frame",     message_out,     e.msg);
        chk("ack_cycle", 256'(cyc),       256'(e.cyc));
        chk("valid",     256'(valid),     256'(1'b1));
        chk("busy",      256'(busy),      256'(1'b1));
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  int unsigned c0;

  initial begin
    blank = {32{8'h20}};
    f_a   = mkframe("HORA 12:00");
    f_b   = mkframe("ALARMA 07:30    LINEA2");
    f_c   = mkframe("MENU            AJUSTES");
    f_d   = mkframe("ALARMA OFF");

    // Asynchronous reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_frame", message_out, blank);
    chk("rst_ack",   256'(ack),       256'(0));
    chk("rst_id",    256'(active_id), 256'(0));
    chk("rst_valid", 256'(valid),     256'(0));
    chk("rst_busy",  256'(busy),      256'(0));
    @(negedge clock);
    reset = 1'b0;

    // Idle: no requests for 10 cycles.
    repeat (10) begin
      @(negedge clock);
      chk("idle_frame", message_out, blank);
      chk("idle_flags", 256'({valid, busy, ack}), 256'(0));
    end

    // Single request with dwell check.
    msg_in[255:0] = f_a;
    req = 3'b001;
    push(3'b001, 3'd0, f_a, cyc + 1);
    @(negedge clock);
    req = 3'b000;
    chk("dwell_busy", 256'(busy), 256'(1));
    @(negedge clock);
    chk("ack_one_cycle", 256'(ack), 256'(0));
    chk("dwell_busy", 256'(busy), 256'(1));
    repeat (2) begin
      @(negedge clock);
      chk("dwell_busy", 256'(busy), 256'(1));
    end
    @(negedge clock);
    chk("dwell_end_busy", 256'(busy), 256'(0));
    chk("dwell_frame", message_out, f_a);

    // All three pending: rotation 0,1,2,0 spaced HOLD+1 cycles.
    do_reset();
    msg_in = {f_c, f_b, f_a};
    req = 3'b111;
    c0 = cyc;
    push(3'b001, 3'd0, f_a, c0 + 1);
    push(3'b010, 3'd1, f_b, c0 + 6);
    push(3'b100, 3'd2, f_c, c0 + 11);
    push(3'b001, 3'd0, f_a, c0 + 16);
    repeat (16) @(negedge clock);
    req = 3'b000;

    // Request arriving during HOLD waits for the dwell to expire.
    do_reset();
    req = 3'b001;
    c0 = cyc;
    push(3'b001, 3'd0, f_a, c0 + 1);
    @(negedge clock);
    req = 3'b100;
    push(3'b100, 3'd2, f_c, c0 + 6);
    repeat (5) @(negedge clock);
    chk("ack_before_rst", 256'(ack), 256'(3'b100));

    // Reset between edges while in HOLD with ack high.
    #1 reset = 1'b1;
    req = 3'b010;
    #1;
    chk("midrst_frame", message_out, blank);
    chk("midrst_ack",   256'(ack),       256'(0));
    chk("midrst_id",    256'(active_id), 256'(0));
    chk("midrst_valid", 256'(valid),     256'(0));
    chk("midrst_busy",  256'(busy),      256'(0));
    @(negedge clock);
    reset = 1'b0;
    push(3'b010, 3'd1, f_b, cyc + 1);

    // Frame latched at grant; later slice changes are ignored.
    @(negedge clock);
    req = 3'b000;
    msg_in[511:256] = f_d;
    chk("char16_map", 256'(message_out[135:128]), 256'(8'h4C));
    repeat (7) begin
      @(negedge clock);
      chk("latched_frame", message_out, f_b);
    end
    req = 3'b010;
    push(3'b010, 3'd1, f_d, cyc + 1);
    @(negedge clock);
    req = 3'b000;
    repeat (3) @(negedge clock);

    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
